notch_out_energy_meter: RTL and testbench
=========================================

// Module: notch_out_energy_meter
// PURPOSE
//  Digital consumer of the notch-filter output (Out node) after ADC sampling.
//  Collects a fixed window of signed samples and reports mean-square energy and mean (DC).
//  Test sequencer uses it to measure notch depth: residual energy with the tone at the notch
//  versus off the notch.
// PARAMETERS
//  DATA_W    16  sample width, signed two's complement
//  WIN_LOG2  10  window length = 2**WIN_LOG2 samples
//  ACC_W     2*DATA_W+WIN_LOG2  internal square accumulator width (derived, do not override)
// PORTS
//  clk       in   1       single clock; all logic on rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  start     in   1       pulse: begin a window; ignored unless IDLE
//  s_valid   in   1       ADC sample valid
//  s_ready   out  1       meter accepts a sample (1 only in ACCUM)
//  s_data    in   DATA_W  signed ADC sample of filter output
//  m_valid   out  1       result valid; held until m_ready
//  m_ready   in   1       result consumer ready
//  m_energy  out  2*DATA_W  unsigned mean square = sum(x^2) >> WIN_LOG2
//  m_mean    out  DATA_W  signed mean = sum(x) >>> WIN_LOG2 (arithmetic, floor)
//  busy      out  1       1 in any state except IDLE
//  m_peak    out  DATA_W  unsigned max |x| over window (only with NOTCH_METER_PEAK_EN)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; accumulators, counter, peak cleared. Async assert,
//   sync deassert at the instantiating level.
//  FSM: IDLE -start-> ACCUM (accumulators cleared same edge)
//   ACCUM -last sample accepted-> DRAIN -1 cycle-> DONE -m_valid&m_ready-> IDLE
//  Sample transfer on s_valid&s_ready edge; no transfer otherwise (stalls hold all state).
//  Square path: one registered pipeline stage (x*x registered), then accumulate.
//   Sum path is delayed to match, so both accumulators are final at the same edge.
//  Latency: last sample accepted at edge E -> m_valid=1 after edge E+2.
//  Counter: WIN_LOG2 bits, wraps to 0 on last sample; last = counter all-ones at transfer.
//  Widths: x*x computed signed, stored unsigned 2*DATA_W; (-2**(DATA_W-1))^2 must not overflow.
//   Sum accumulator DATA_W+WIN_LOG2 signed; no saturation needed.
//  DONE: m_energy/m_mean/m_peak stable while m_valid=1 and m_ready=0.
//  start while busy: ignored, no effect on window. start same cycle as DONE handshake:
//   ignored (goes IDLE); a new start is needed.
//  Reset mid-window: partial results discarded; m_valid never asserted for that window.
// CONFIGURATION
//  NOTCH_METER_PEAK_EN defined: m_peak port present; |x| tracked in ACCUM, max registered,
//   |-2**(DATA_W-1)| = 2**(DATA_W-1) representable as unsigned DATA_W.
//  Undefined: no m_peak port, no peak logic; all other behaviour identical.
// STRUCTURE
//  Package notch_meter_pkg: state enum {IDLE,ACCUM,DRAIN,DONE}; function ACC_W_F(d,w);
//   default DATA_W/WIN_LOG2 constants.
//  Sub-module sq_accum: registered squarer + square/sum accumulators with clear and enable;
//   top holds FSM, counter, handshake, peak.
// TESTING (bench uses DATA_W=16, WIN_LOG2=4)
//  16 samples of +100, s_valid always 1 -> m_energy=10000, m_mean=100, m_peak=100,
//   m_valid 2 cycles after last transfer.
//  Alternating +1000/-1000 -> m_energy=1000000, m_mean=0, m_peak=1000.
//  16 samples of -32768 -> m_energy=1073741824, m_mean=-32768, m_peak=32768.
//  Random s_valid gaps and m_ready low 5 cycles in DONE -> same results as gapless;
//   outputs stable while stalled.
//  start pulsed mid-window and on the DONE handshake cycle -> no restart;
//   busy drops after handshake.
//  rst_n low after 7 samples, then new window of +5 -> only one m_valid: m_energy=25, m_mean=5.

Source files
------------

// File: rtl/notch_meter_pkg.sv
// notch_meter_pkg: shared state encoding, default sizes and accumulator width helper
// for the notch-output energy meter.
package notch_meter_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int WIN_LOG2_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Square accumulator must hold 2**w full-scale squares without wrapping.
    function automatic int ACC_W_F(input int d, input int w);
        return 2 * d + w;
    endfunction

endpackage

// File: rtl/sq_accum.sv
// sq_accum: registered squarer feeding square and sum accumulators; the sum path is
// delayed one stage so both totals settle on the same edge.
module sq_accum
    import notch_meter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int ACC_W    = ACC_W_F(DATA_W, WIN_LOG2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [DATA_W-1:0]   x,
    output logic [2*DATA_W-1:0] energy,
    output logic [DATA_W-1:0]   mean
);

    logic signed [2*DATA_W-1:0]        x_ext;
    logic signed [2*DATA_W-1:0]        prod;
    logic        [2*DATA_W-1:0]        sq;
    logic        [DATA_W-1:0]          x_d;
    logic                              v_d;
    logic        [ACC_W-1:0]           acc;
    logic        [DATA_W+WIN_LOG2-1:0] sum;

    // (-2**(DATA_W-1))**2 = 2**(2*DATA_W-2) still fits in 2*DATA_W bits
    assign x_ext  = $signed({{DATA_W{x[DATA_W-1]}}, x});
    assign prod   = x_ext * x_ext;
    assign energy = acc[ACC_W-1:WIN_LOG2];
    assign mean   = sum[DATA_W+WIN_LOG2-1:WIN_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq  <= '0;
            x_d <= '0;
            v_d <= 1'b0;
            acc <= '0;
            sum <= '0;
        end else if (clr) begin
            sq  <= '0;
            x_d <= '0;
            v_d <= 1'b0;
            acc <= '0;
            sum <= '0;
        end else begin
            v_d <= en;
            if (en) begin
                sq  <= prod;
                x_d <= x;
            end
            if (v_d) begin
                acc <= acc + {{(ACC_W-2*DATA_W){1'b0}}, sq};
                sum <= sum + {{WIN_LOG2{x_d[DATA_W-1]}}, x_d};
            end
        end
    end

endmodule

// File: rtl/notch_out_energy_meter.sv
// notch_out_energy_meter: collects 2**WIN_LOG2 signed samples, reports mean square and mean.
// Define NOTCH_METER_PEAK_EN to add the m_peak output (max |x| over the window).
module notch_out_energy_meter
    import notch_meter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*DATA_W-1:0] m_energy,
    output logic [DATA_W-1:0]   m_mean,
    output logic                busy
`ifdef NOTCH_METER_PEAK_EN
    ,
    output logic [DATA_W-1:0]   m_peak
`endif
);

    localparam int ACC_W = ACC_W_F(DATA_W, WIN_LOG2);

    state_t                state;
    logic [WIN_LOG2-1:0]   cnt;
    logic                  xfer;
    logic                  clr;
    logic [2*DATA_W-1:0]   energy;
    logic [DATA_W-1:0]     mean;

    assign s_ready = (state == ACCUM);
    assign busy    = (state != IDLE);
    assign xfer    = s_valid && s_ready;
    assign clr     = (state == IDLE) && start;

    sq_accum #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2),
        .ACC_W    (ACC_W)
    ) u_sq_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .en     (xfer),
        .x      (s_data),
        .energy (energy),
        .mean   (mean)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            m_valid  <= 1'b0;
            m_energy <= '0;
            m_mean   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        cnt <= cnt + WIN_LOG2'(1);
                        if (&cnt) state <= DRAIN;
                    end
                end
                DRAIN: state <= DONE;
                DONE: begin
                    // first DONE cycle latches the settled totals, later cycles wait for m_ready
                    if (!m_valid) begin
                        m_valid  <= 1'b1;
                        m_energy <= energy;
                        m_mean   <= mean;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOTCH_METER_PEAK_EN
    logic [DATA_W-1:0] x_abs;
    logic [DATA_W-1:0] peak;

    assign x_abs = s_data[DATA_W-1] ? (~s_data + DATA_W'(1)) : s_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak   <= '0;
            m_peak <= '0;
        end else begin
            if (clr) peak <= '0;
            else if (xfer && x_abs > peak) peak <= x_abs;
            if (state == DONE && !m_valid) m_peak <= peak;
        end
    end
`endif

endmodule

// File: tb/tb_notch_out_energy_meter.sv
// tb_notch_out_energy_meter: table-driven and random windows checked against an arithmetic model.
// Peak checks are compiled in when NOTCH_METER_PEAK_EN is defined.
module tb_notch_out_energy_meter;

    localparam int DW = 16;
    localparam int WL = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic          busy;
    logic [2*DW-1:0] m_energy;
    logic [DW-1:0] m_mean;
`ifdef NOTCH_METER_PEAK_EN
    logic [DW-1:0] m_peak;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    notch_out_energy_meter #(.DATA_W(DW), .WIN_LOG2(WL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_energy (m_energy),
        .m_mean   (m_mean),
        .busy     (busy)
`ifdef NOTCH_METER_PEAK_EN
        ,
        .m_peak   (m_peak)
`endif
    );

    typedef struct {
        int     kind;
        int     val;
        bit     gaps;
        int     stall;
        bit     poke;
        longint e;
        longint m;
        longint p;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Floor mean and floor mean-square from plain integer arithmetic.
    task automatic model(input int xs[N], output longint e, output longint m, output longint p);
        longint s = 0;
        longint q = 0;
        longint a;
        p = 0;
        for (int i = 0; i < N; i++) begin
            s += xs[i];
            q += longint'(xs[i]) * longint'(xs[i]);
            a = xs[i] < 0 ? -longint'(xs[i]) : longint'(xs[i]);
            if (a > p) p = a;
        end
        e = q / N;
        m = (s - (((s % N) + N) % N)) / N;
    endtask

    task automatic chk_out(input string tag, input longint e, input longint m, input longint p);
        chk({tag, " energy"}, longint'(m_energy), e);
        chk({tag, " mean"}, longint'($signed(m_mean)), m);
`ifdef NOTCH_METER_PEAK_EN
        chk({tag, " peak"}, longint'(m_peak), p);
`else
        if (p < 0) chk({tag, " model peak"}, p, 0);
`endif
    endtask

    task automatic run_win(input string tag, input int xs[N], input bit gaps, input int stall,
                           input bit poke, output longint ge, output longint gm, output longint gp);
        longint e, m, p;
        int idx = 0;
        int cyc = 0;
        model(xs, e, m, p);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy after start"}, longint'(busy), 1);
        chk({tag, " s_ready after start"}, longint'(s_ready), 1);
        while (idx < N && cyc < 400) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = xs[idx][DW-1:0];
            start   = poke && (idx == 7);
            if (s_valid && s_ready) idx++;
            cyc++;
            @(negedge clk);
            if (m_valid) chk({tag, " early m_valid"}, longint'(m_valid), 0);
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (idx < N) chk({tag, " sample timeout"}, idx, N);
        chk({tag, " m_valid after E"}, longint'(m_valid), 0);
        @(negedge clk);
        chk({tag, " m_valid after E+1"}, longint'(m_valid), 0);
        @(negedge clk);
        chk({tag, " m_valid after E+2"}, longint'(m_valid), 1);
        chk_out(tag, e, m, p);
        ge = longint'(m_energy);
        gm = longint'($signed(m_mean));
`ifdef NOTCH_METER_PEAK_EN
        gp = longint'(m_peak);
`else
        gp = p;
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, " m_valid held"}, longint'(m_valid), 1);
            chk_out({tag, " stalled"}, e, m, p);
        end
        m_ready = 1'b1;
        start   = poke;
        @(negedge clk);
        m_ready = 1'b0;
        start   = 1'b0;
        chk({tag, " m_valid after handshake"}, longint'(m_valid), 0);
        chk({tag, " busy after handshake"}, longint'(busy), 0);
        @(negedge clk);
        chk({tag, " busy stays low"}, longint'(busy), 0);
    endtask

    initial begin
        vec_t   tbl[5];
        int     xs[N];
        longint ge, gm, gp, e, m, p;
        bit     seen;

        tbl[0] = '{0, 100,    0, 0, 0, 10000,      100,    100};
        tbl[1] = '{1, 1000,   0, 0, 0, 1000000,    0,      1000};
        tbl[2] = '{0, -32768, 0, 0, 0, 1073741824, -32768, 32768};
        tbl[3] = '{0, 100,    1, 5, 0, 10000,      100,    100};
        tbl[4] = '{1, 1000,   1, 5, 1, 1000000,    0,      1000};

        repeat (3) @(negedge clk);
        chk("reset m_valid", longint'(m_valid), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset s_ready", longint'(s_ready), 0);
        chk("reset energy", longint'(m_energy), 0);
        chk("reset mean", longint'(m_mean), 0);
        rst_n = 1'b1;

        foreach (tbl[t]) begin
            for (int i = 0; i < N; i++)
                xs[i] = (tbl[t].kind == 1 && i % 2 == 1) ? -tbl[t].val : tbl[t].val;
            run_win($sformatf("tbl%0d", t), xs, tbl[t].gaps, tbl[t].stall, tbl[t].poke, ge, gm, gp);
            chk($sformatf("tbl%0d table energy", t), ge, tbl[t].e);
            chk($sformatf("tbl%0d table mean", t), gm, tbl[t].m);
`ifdef NOTCH_METER_PEAK_EN
            chk($sformatf("tbl%0d table peak", t), gp, tbl[t].p);
`endif
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                xs[i] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            run_win($sformatf("rnd%0d", r), xs, r[0], int'($urandom_range(0, 3)), r[1], ge, gm, gp);
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'd1234;
        repeat (7) @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("midreset busy", longint'(busy), 0);
        chk("midreset m_valid", longint'(m_valid), 0);
        chk("midreset energy", longint'(m_energy), 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= m_valid;
        end
        chk("midreset no stale m_valid", longint'(seen), 0);
        for (int i = 0; i < N; i++) xs[i] = 5;
        run_win("post-reset", xs, 0, 1, 0, ge, gm, gp);
        model(xs, e, m, p);
        chk("post-reset energy", ge, 25);
        chk("post-reset mean", gm, 5);
        chk("post-reset model agrees", e, 25);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
